uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   Transmit serializer fed by the transmitter FIFO. Pops one byte at a time
//   through a read-enable/empty handshake and frames it: start bit, data LSB
//   first, optional parity, then stop bit(s). Drives the UART TX line at a
//   baud rate set by an internal clock divider. Sits between the transmitter
//   FIFO and the TX pad.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//   DATA_BITS     8   data bits per frame, 5..8; fifo_data[DATA_BITS-1:0] is sent
//   PARITY_EN     0   1 = insert parity bit after the data bits
//   PARITY_ODD    0   0 = even parity, 1 = odd parity; used only when PARITY_EN=1
//   STOP_BITS     1   stop bits per frame, 1 or 2
// PORTS
//   clk         in   1  system clock; all logic on the rising edge
//   reset_n     in   1  asynchronous, active-low reset
//   fifo_empty  in   1  FIFO has no data
//   fifo_data   in   8  FIFO read data; valid the cycle after fifo_rd_en
//   fifo_rd_en  out  1  one-cycle pop request to the FIFO
//   tx          out  1  serial line; idles high
//   busy        out  1  high from the pop request until the last stop bit ends
//   tx_done     out  1  one-cycle pulse when a frame's last stop bit completes
// BEHAVIOUR
//   - Reset (reset_n=0, async): tx=1, fifo_rd_en=0, busy=0, tx_done=0, state
//     IDLE, baud counter=0, bit counter=0, shift register=0. A frame in progress
//     is dropped and the line returns high at once. No partial frame resumes.
//   - FSM states: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
//     IDLE  : tx=1. If fifo_empty=0, go to REQ next cycle.
//     REQ   : exactly one cycle. fifo_rd_en=1, busy=1. Go to LOAD.
//     LOAD  : exactly one cycle. Latch fifo_data into the shift register and
//             compute parity (even = ^data, odd = ~^data). Clear the baud
//             counter. Go to START.
//     START : tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//     DATA  : send shift register bit 0 and shift right every CLKS_PER_BIT
//             cycles. After DATA_BITS bits, go to PARITY if PARITY_EN=1,
//             otherwise go to STOP.
//     PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
//     STOP  : tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle,
//             tx_done=1, then go to IDLE.
//   - tx, fifo_rd_en, busy and tx_done are registered (no combinational path
//     from any input). tx first goes low in the first START cycle, which is
//     3 clocks after the first IDLE cycle that sees fifo_empty=0.
//   - Every bit lasts exactly CLKS_PER_BIT clocks. The baud counter counts
//     0..CLKS_PER_BIT-1, wraps to 0, and advances the bit on wrap. Its width
//     is $clog2(CLKS_PER_BIT).
//   - Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT
//     clocks of tx activity.
//   - Back-to-back frames: the cycle after tx_done, the FSM is in IDLE. If
//     fifo_empty=0 there, it goes straight to REQ. There is one idle-high
//     clock plus REQ and LOAD (3 clocks total) added beyond the stop bits.
//   - fifo_empty is sampled only in IDLE. Changes during a frame are ignored.
//     Exactly one fifo_rd_en pulse is issued per frame; a pop is never issued
//     while busy is already high.
//   - DATA_BITS<8: upper bits of fifo_data are ignored.
// TESTING
//   1. Reset release, fifo_empty=1 for 100 clks -> tx=1, fifo_rd_en never
//      asserts, busy=0.
//   2. Defaults with CLKS_PER_BIT=4, send 0xA5 -> one fifo_rd_en pulse; tx =
//      0,1,0,1,0,0,1,0,1,1, each bit 4 clks; tx_done pulses once after 40 clks
//      of frame.
//   3. PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit = 1. With
//      PARITY_ODD=1 -> parity bit = 0. STOP_BITS=2 -> stop high for 8 clks.
//   4. FIFO holds 3 bytes 0x00, 0xFF, 0x3C -> three frames, in that order, with
//      exactly 3 clks between tx_done and the next start bit; 3 fifo_rd_en
//      pulses total.
//   5. Assert reset_n=0 during data bit 4 of a frame -> tx=1 immediately. After
//      release, FSM is in IDLE and no stale bits are sent. The next frame
//      starts only if fifo_empty=0.
//   6. fifo_empty toggles mid-frame -> no extra fifo_rd_en; frame timing is
//      unchanged.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them
// (start, data LSB first, optional parity, stop bits) at CLKS_PER_BIT clocks per bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [BAUD_W-1:0]      r_baud;
  logic [2:0]             r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic                   r_tx;
  logic                   r_rd_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_wrap;
  logic                   w_tx_next;
  logic                   w_done_next;

  assign w_wrap = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Outputs are computed for the upcoming state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    w_next      = r_state;
    w_tx_next   = 1'b1;
    w_done_next = 1'b0;
    case (r_state)
      S_IDLE:   if (!fifo_empty) w_next = S_REQ;
      S_REQ:    w_next = S_LOAD;
      S_LOAD:   w_next = S_START;
      S_START:  if (w_wrap) w_next = S_DATA;
      S_DATA:   if (w_wrap && r_bit == DATA_LAST)
                  w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_wrap) w_next = S_STOP;
      S_STOP:   if (w_wrap && r_bit == STOP_LAST) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    case (w_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = (r_state == S_DATA && w_wrap) ? r_shift[1] : r_shift[0];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase
    w_done_next = (r_state == S_STOP) && !w_wrap && (r_baud == BAUD_PRE) &&
                  (r_bit == STOP_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tx    <= w_tx_next;
      r_rd_en <= (w_next == S_REQ);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_done_next;
      case (r_state)
        S_LOAD: begin
          r_shift  <= fifo_data[DATA_BITS-1:0];
          r_parity <= (^fifo_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
          r_baud   <= '0;
          r_bit    <= '0;
        end
        S_START, S_PARITY: r_baud <= w_wrap ? '0 : r_baud + 1'b1;
        S_DATA: begin
          r_baud <= w_wrap ? '0 : r_baud + 1'b1;
          if (w_wrap) begin
            r_shift <= r_shift >> 1;
            r_bit   <= (r_bit == DATA_LAST) ? 3'd0 : r_bit + 3'd1;
          end
        end
        S_STOP: begin
          r_baud <= w_wrap ? '0 : r_baud + 1'b1;
          if (w_wrap) r_bit <= (r_bit == STOP_LAST) ? 3'd0 : r_bit + 3'd1;
        end
        default: r_baud <= '0;
      endcase
    end
  end

  assign tx         = r_tx;
  assign fifo_rd_en = r_rd_en;
  assign busy       = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: three serializer configurations fed by FIFO models,
// with a byte scoreboard and a cycle-accurate frame checker.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] fifoEmpty;
  logic [2:0] fifoRdEn;
  logic [2:0] txLine;
  logic [2:0] busyV;
  logic [2:0] txDoneV;
  logic [2:0] glitch = 3'b000;
  logic [7:0] fifoData [3];
  logic [7:0] mem [3][64];
  int         wrPtr [3] = '{0, 0, 0};
  int         rdPtr [3] = '{0, 0, 0};
  int         rdCount [3] = '{0, 0, 0};
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbQ [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: empty follows the pointers, glitch forces a false not-empty
  always_comb begin
    fifoEmpty = 3'b000;
    for (int i = 0; i < 3; i++)
      fifoEmpty[i] = (wrPtr[i] == rdPtr[i]) & ~glitch[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifoRdEn[i]) begin
        rdCount[i]  <= rdCount[i] + 1;
        fifoData[i] <= mem[i][rdPtr[i] % 64];
        rdPtr[i]    <= rdPtr[i] + 1;
      end
    end
  end

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u0 (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifoEmpty[0]), .fifo_data(fifoData[0]),
    .fifo_rd_en(fifoRdEn[0]), .tx(txLine[0]), .busy(busyV[0]), .tx_done(txDoneV[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifoEmpty[1]), .fifo_data(fifoData[1]),
    .fifo_rd_en(fifoRdEn[1]), .tx(txLine[1]), .busy(busyV[1]), .tx_done(txDoneV[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                       .STOP_BITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifoEmpty[2]), .fifo_data(fifoData[2]),
    .fifo_rd_en(fifoRdEn[2]), .tx(txLine[2]), .busy(busyV[2]), .tx_done(txDoneV[2]));

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Writes one byte into an instance's FIFO and records it on the scoreboard
  task automatic applyStimulus(input int idx, input logic [7:0] b);
    mem[idx][wrPtr[idx] % 64] = b;
    wrPtr[idx] = wrPtr[idx] + 1;
    sbQ.push_back(b);
  endtask

  // Waits for a start bit, then checks {tx,busy,tx_done} every clock of the frame
  task automatic expectFrame(input int idx, output int startCyc, output int doneCyc);
    int          n;
    int          db;
    int          nb;
    int          sb;
    bit          pe;
    bit          po;
    logic [7:0]  d;
    logic [7:0]  mask;
    logic [15:0] fb;
    logic [2:0]  exp;
    db = (idx == 2) ? 7 : 8;
    pe = (idx != 0);
    po = (idx == 2);
    sb = (idx == 0) ? 1 : 2;
    startCyc = -1;
    doneCyc = -1;
    n = 0;
    while (txLine[idx] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    startCyc = cyc;
    if (txLine[idx] !== 1'b0) begin
      checkOutput($sformatf("startSeen%0d", idx), {31'd0, txLine[idx]}, 32'd0);
      return;
    end
    if (sbQ.size() == 0) begin
      checkOutput("scoreboardEmpty", sbQ.size(), 32'd1);
      return;
    end
    mask = 8'hFF >> (8 - db);
    d = sbQ.pop_front() & mask;
    fb = '1;
    fb[0] = 1'b0;
    for (int j = 0; j < db; j++) fb[1 + j] = d[j];
    nb = 1 + db;
    if (pe) begin
      fb[nb] = (^d) ^ po;
      nb++;
    end
    nb = nb + sb;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        exp = {fb[b], 1'b1, (b == nb - 1 && c == CPB - 1)};
        checkOutput($sformatf("frame%0d byte%02h bit%0d clk%0d", idx, d, b, c),
                    {29'd0, txLine[idx], busyV[idx], txDoneV[idx]}, {29'd0, exp});
        if (b == nb - 1 && c == CPB - 1) doneCyc = cyc;
        @(negedge clk);
      end
    end
    checkOutput($sformatf("postFrame%0d", idx),
                {29'd0, txLine[idx], busyV[idx], txDoneV[idx]}, 32'b100);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int d;
    int s2;
    int d2;
    int pc;
    int cnt;
    int n;
    logic [7:0] junk;

    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("resetState%0d", i),
                  {28'd0, txLine[i], busyV[i], fifoRdEn[i], txDoneV[i]}, 32'b1000);
    reset_n = 1'b1;

    // Idle with empty FIFOs: line stays high, nothing popped
    $display("[TB] idle check");
    repeat (100) begin
      @(negedge clk);
      checkOutput("idleLines", {23'd0, txLine, busyV, fifoRdEn}, {23'd0, 3'b111, 3'b000, 3'b000});
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("idlePops%0d", i), rdCount[i], 32'd0);

    // Single frame 0xA5 with default framing
    $display("[TB] single frame");
    pc = cyc;
    applyStimulus(0, 8'hA5);
    expectFrame(0, s, d);
    checkOutput("latencyA5", s - pc, 32'd3);
    checkOutput("lengthA5", d - s + 1, 32'd40);
    checkOutput("popsA5", rdCount[0], 32'd1);

    // Parity variants with two stop bits
    $display("[TB] parity frames");
    applyStimulus(1, 8'h07);
    expectFrame(1, s, d);
    checkOutput("lengthEven", d - s + 1, 32'd48);
    checkOutput("popsEven", rdCount[1], 32'd1);
    applyStimulus(2, 8'h87);
    expectFrame(2, s, d);
    checkOutput("lengthOdd7", d - s + 1, 32'd44);
    checkOutput("popsOdd7", rdCount[2], 32'd1);

    // Back-to-back frames
    $display("[TB] back-to-back frames");
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    applyStimulus(0, 8'h3C);
    expectFrame(0, s, d);
    expectFrame(0, s2, d2);
    checkOutput("gap1", s2 - d, 32'd4);
    expectFrame(0, s, d);
    checkOutput("gap2", s - d2, 32'd4);
    checkOutput("popsB2B", rdCount[0], 32'd4);

    // Reset during data bit 4
    $display("[TB] mid-frame reset");
    applyStimulus(0, 8'hA5);
    n = 0;
    while (txLine[0] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abortStart", {31'd0, txLine[0]}, 32'd0);
    if (sbQ.size() != 0) junk = sbQ.pop_front();
    repeat (CPB * 5 + 1) @(negedge clk);
    checkOutput("abortBit4", {30'd0, txLine[0], busyV[0]}, 32'b01);
    #2 reset_n = 1'b0;
    #1 checkOutput("abortReset", {28'd0, txLine[0], busyV[0], fifoRdEn[0], txDoneV[0]}, 32'b1000);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = rdCount[0];
    repeat (50) begin
      @(negedge clk);
      checkOutput("afterAbort", {30'd0, txLine[0], busyV[0]}, 32'b10);
    end
    checkOutput("afterAbortPops", rdCount[0], cnt);
    applyStimulus(0, 8'hC3);
    expectFrame(0, s, d);
    checkOutput("popsAfterAbort", rdCount[0], cnt + 1);

    // fifo_empty glitching mid-frame
    $display("[TB] empty toggling");
    cnt = rdCount[0];
    pc = cyc;
    applyStimulus(0, 8'h96);
    fork
      expectFrame(0, s, d);
      begin
        repeat (12) @(negedge clk);
        repeat (5) begin
          glitch[0] = 1'b1;
          @(negedge clk);
          glitch[0] = 1'b0;
          @(negedge clk);
        end
      end
    join
    checkOutput("latencyGlitch", s - pc, 32'd3);
    checkOutput("lengthGlitch", d - s + 1, 32'd40);
    repeat (10) @(negedge clk);
    checkOutput("popsGlitch", rdCount[0], cnt + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
